// File: rtl/mesh_phase_sequencer_if.sv
// Control and broadcast bundle between the mesh phase sequencer and the
// block that drives it and watches its progress.
interface mesh_phase_sequencer_if #(
  parameter int CNT_WIDTH = 10
);
  logic                 start;
  logic                 stop;
  logic                 stall;
  logic [1:0]           pass;
  logic [2:0]           phase;
  logic [CNT_WIDTH-1:0] step;
  logic                 step_en;
  logic                 phase_last;
  logic                 busy;
  logic                 round_done;
  logic [15:0]          rounds;

  modport master (
    output start, stop, stall,
    input  pass, phase, step, step_en, phase_last, busy, round_done, rounds
  );

  modport slave (
    input  start, stop, stall,
    output pass, phase, step, step_en, phase_last, busy, round_done, rounds
  );
endinterface

// File: rtl/mesh_phase_sequencer.sv
// Shared pass/phase/step sequencer for the PE sorting mesh. It runs
// PUSH_ADDR and GET_DATA sort passes followed by a short COMPUTE phase, repeating.
module mesh_phase_sequencer #(
  parameter int SQRT_N         = 32,
  parameter int SORT_CYCLES    = 222,
  parameter int COMPUTE_CYCLES = 3,
  parameter int CNT_WIDTH      = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mesh_phase_sequencer_if.slave  bus
);

  localparam logic [1:0] PASS_PUSH    = 2'b00;
  localparam logic [1:0] PASS_GET     = 2'b01;
  localparam logic [1:0] PASS_COMPUTE = 2'b10;
  localparam logic [1:0] PASS_IDLE    = 2'b11;

  localparam logic [2:0] PH_SORT = 3'b000;
  localparam logic [2:0] PH_ROW  = 3'b001;
  localparam logic [2:0] PH_COL  = 3'b010;
  localparam logic [2:0] PH_NOP  = 3'b111;

  localparam logic [CNT_WIDTH-1:0] SORT_LAST  = CNT_WIDTH'(SORT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ALIGN_LAST = CNT_WIDTH'(SQRT_N - 1);
  localparam logic [CNT_WIDTH-1:0] NOP_LAST   = CNT_WIDTH'(COMPUTE_CYCLES - 1);

  logic [1:0]           pass_q, pass_d;
  logic [2:0]           phase_q, phase_d;
  logic [CNT_WIDTH-1:0] step_q, step_d;
  logic                 phase_last_q, phase_last_d;
  logic                 busy_q, busy_d;
  logic                 round_done_q, round_done_d;
  logic [15:0]          rounds_q, rounds_d;
  logic                 stop_pending_q, stop_pending_d;
  logic                 step_en;

  function automatic logic [CNT_WIDTH-1:0] last_step(input logic [2:0] ph);
    case (ph)
      PH_SORT:        return SORT_LAST;
      PH_ROW, PH_COL: return ALIGN_LAST;
      default:        return NOP_LAST;
    endcase
  endfunction

  assign step_en = busy_q & ~bus.stall;

  always_comb begin
    pass_d         = pass_q;
    phase_d        = phase_q;
    step_d         = step_q;
    stop_pending_d = stop_pending_q;
    rounds_d       = rounds_q;
    round_done_d   = 1'b0;

    if (!busy_q) begin
      // A start coincident with stop arms exactly one round.
      if (bus.start) begin
        pass_d         = PASS_PUSH;
        phase_d        = PH_SORT;
        step_d         = '0;
        stop_pending_d = bus.stop;
      end
    end else begin
      if (bus.stop) begin
        stop_pending_d = 1'b1;
      end
      if (step_en) begin
        if (!phase_last_q) begin
          step_d = step_q + CNT_WIDTH'(1);
        end else begin
          step_d = '0;
          case (phase_q)
            PH_SORT: phase_d = PH_ROW;
            PH_ROW:  phase_d = PH_COL;
            PH_COL: begin
              if (pass_q == PASS_PUSH) begin
                pass_d  = PASS_GET;
                phase_d = PH_SORT;
              end else begin
                pass_d  = PASS_COMPUTE;
                phase_d = PH_NOP;
              end
            end
            default: begin
              // Final compute step: the round is complete.
              round_done_d = 1'b1;
              rounds_d     = rounds_q + 16'd1;
              if (stop_pending_d) begin
                pass_d         = PASS_IDLE;
                phase_d        = PH_NOP;
                stop_pending_d = 1'b0;
              end else begin
                pass_d  = PASS_PUSH;
                phase_d = PH_SORT;
              end
            end
          endcase
        end
      end
    end

    busy_d       = (pass_d != PASS_IDLE);
    phase_last_d = busy_d && (step_d == last_step(phase_d));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_q         <= PASS_IDLE;
      phase_q        <= PH_NOP;
      step_q         <= '0;
      phase_last_q   <= 1'b0;
      busy_q         <= 1'b0;
      round_done_q   <= 1'b0;
      rounds_q       <= '0;
      stop_pending_q <= 1'b0;
    end else begin
      pass_q         <= pass_d;
      phase_q        <= phase_d;
      step_q         <= step_d;
      phase_last_q   <= phase_last_d;
      busy_q         <= busy_d;
      round_done_q   <= round_done_d;
      rounds_q       <= rounds_d;
      stop_pending_q <= stop_pending_d;
    end
  end

  assign bus.pass       = pass_q;
  assign bus.phase      = phase_q;
  assign bus.step       = step_q;
  assign bus.step_en    = step_en;
  assign bus.phase_last = phase_last_q;
  assign bus.busy       = busy_q;
  assign bus.round_done = round_done_q;
  assign bus.rounds     = rounds_q;

endmodule

// File: tb/tb_mesh_phase_sequencer.sv
// Directed bench: small-mesh instance for round/stop/stall/reset/wrap
// behaviour, plus a unit-length instance.
module tb_mesh_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a;
  logic rst_n_b;

  mesh_phase_sequencer_if #(.CNT_WIDTH(10)) bus_a ();
  mesh_phase_sequencer_if #(.CNT_WIDTH(10)) bus_b ();

  mesh_phase_sequencer #(
    .SQRT_N(2), .SORT_CYCLES(5), .COMPUTE_CYCLES(3), .CNT_WIDTH(10)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(bus_a.slave)
  );

  mesh_phase_sequencer #(
    .SQRT_N(1), .SORT_CYCLES(1), .COMPUTE_CYCLES(1), .CNT_WIDTH(10)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Expected round for SQRT_N=2, SORT_CYCLES=5, COMPUTE_CYCLES=3
  int pa_t[7] = '{0, 0, 0, 1, 1, 1, 2};
  int ph_t[7] = '{0, 1, 2, 0, 1, 2, 7};
  int ln_t[7] = '{5, 2, 2, 5, 2, 2, 3};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic exp_a(input string at, input int pa, input int ph, input int st,
                       input int last, input int en, input int rd);
    check_val({"pass@", at},       32'(bus_a.pass),       32'(pa));
    check_val({"phase@", at},      32'(bus_a.phase),      32'(ph));
    check_val({"step@", at},       32'(bus_a.step),       32'(st));
    check_val({"phase_last@", at}, 32'(bus_a.phase_last), 32'(last));
    check_val({"busy@", at},       32'(bus_a.busy),       32'd1);
    check_val({"step_en@", at},    32'(bus_a.step_en),    32'(en));
    check_val({"round_done@", at}, 32'(bus_a.round_done), 32'(rd));
  endtask

  task automatic idle_a(input string at, input int rd, input int rnds);
    check_val({"idle_pass@", at},  32'(bus_a.pass),       32'd3);
    check_val({"idle_phase@", at}, 32'(bus_a.phase),      32'd7);
    check_val({"idle_step@", at},  32'(bus_a.step),       32'd0);
    check_val({"idle_busy@", at},  32'(bus_a.busy),       32'd0);
    check_val({"idle_en@", at},    32'(bus_a.step_en),    32'd0);
    check_val({"idle_last@", at},  32'(bus_a.phase_last), 32'd0);
    check_val({"idle_rdone@", at}, 32'(bus_a.round_done), 32'(rd));
    check_val({"idle_rounds@", at},32'(bus_a.rounds),     32'(rnds));
  endtask

  task automatic reset_a();
    rst_n_a = 1'b0;
    bus_a.start = 1'b0;
    bus_a.stop  = 1'b0;
    bus_a.stall = 1'b0;
    cyc();
    rst_n_a = 1'b1;
    #1;
    idle_a("reset", 0, 0);
  endtask

  // Walks one round on dut_a from the current (first active) cycle.
  task automatic round_a(input bit rd0, input int stall_idx, input int stall_len,
                         input int stop_idx, input int abort_idx, input bit spam_start,
                         output int ncyc);
    int idx = 0;
    ncyc = 0;
    for (int e = 0; e < 7; e++) begin
      for (int s = 0; s < ln_t[e]; s++) begin
        string at = $sformatf("%0d", idx);
        int last = (s == ln_t[e] - 1) ? 1 : 0;
        int rd = (idx == 0 && rd0) ? 1 : 0;
        if (idx == stall_idx) begin
          for (int k = 0; k < stall_len; k++) begin
            bus_a.stall = 1'b1;
            #1;
            exp_a({at, "s"}, pa_t[e], ph_t[e], s, last, 0, rd);
            ncyc++;
            cyc();
          end
        end
        bus_a.stall = 1'b0;
        bus_a.stop  = (idx == stop_idx);
        bus_a.start = spam_start;
        #1;
        exp_a(at, pa_t[e], ph_t[e], s, last, 1, rd);
        ncyc++;
        if (idx == abort_idx) return;
        cyc();
        bus_a.start = 1'b0;
        bus_a.stop  = 1'b0;
        idx++;
      end
    end
    $display("round on dut_a: %0d busy cycles, rounds now %0d", ncyc, bus_a.rounds);
  endtask

  initial begin
    int n;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.stall = 1'b0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.stall = 1'b0;
    @(negedge clk);

    // Single round: start with stop
    reset_a();
    bus_a.start = 1'b1; bus_a.stop = 1'b1;
    cyc();
    round_a(0, -1, 0, -1, -1, 0, n);
    check_val("single_len", 32'(n), 32'd21);
    idle_a("single_end", 1, 1);
    cyc(); #1;
    idle_a("single_after", 0, 1);

    // Continuous: stop during cycle 30 (round 2 index 8)
    reset_a();
    bus_a.start = 1'b1;
    cyc();
    bus_a.start = 1'b0;
    round_a(0, -1, 0, -1, -1, 0, n);
    round_a(1, -1, 0, 8, -1, 0, n);
    idle_a("cont_end", 1, 2);

    // Stall 4 cycles at GET_DATA/ROW_ALIGN step 1
    reset_a();
    bus_a.start = 1'b1; bus_a.stop = 1'b1;
    cyc();
    round_a(0, 15, 4, -1, -1, 0, n);
    check_val("stall_len", 32'(n), 32'd25);
    idle_a("stall_end", 1, 1);

    // Reset mid-round at PUSH_ADDR/COL_ALIGN step 1
    reset_a();
    bus_a.start = 1'b1;
    cyc();
    bus_a.start = 1'b0;
    round_a(0, -1, 0, -1, 8, 0, n);
    rst_n_a = 1'b0; bus_a.stall = 1'b1; bus_a.start = 1'b1; bus_a.stop = 1'b1;
    cyc();
    rst_n_a = 1'b1; bus_a.stall = 1'b0; bus_a.start = 1'b0; bus_a.stop = 1'b0;
    #1;
    idle_a("midrst", 0, 0);
    bus_a.start = 1'b1; bus_a.stop = 1'b1;
    cyc();
    round_a(0, -1, 0, -1, -1, 0, n);
    check_val("midrst_len", 32'(n), 32'd21);
    idle_a("midrst_end", 1, 1);

    // Start pulses while busy are ignored
    reset_a();
    bus_a.start = 1'b1; bus_a.stop = 1'b1;
    cyc();
    round_a(0, -1, 0, -1, -1, 1, n);
    check_val("ign_len", 32'(n), 32'd21);
    idle_a("ign_end", 1, 1);
    cyc(); #1;
    idle_a("ign_after", 0, 1);

    // Rounds counter wrap
    force dut_a.rounds_q = 16'hFFFF;
    #1;
    release dut_a.rounds_q;
    #1;
    check_val("wrap_preload", 32'(bus_a.rounds), 32'h0000FFFF);
    bus_a.start = 1'b1; bus_a.stop = 1'b1;
    cyc();
    round_a(0, -1, 0, -1, -1, 0, n);
    idle_a("wrap_end", 1, 0);

    // Unit phase lengths on dut_b: 7-cycle round, step 0, phase_last 1
    rst_n_b = 1'b0;
    cyc();
    rst_n_b = 1'b1;
    #1;
    check_val("b_reset_pass", 32'(bus_b.pass),       32'd3);
    check_val("b_reset_last", 32'(bus_b.phase_last), 32'd0);
    bus_b.start = 1'b1; bus_b.stop = 1'b1;
    cyc();
    bus_b.start = 1'b0; bus_b.stop = 1'b0;
    for (int e = 0; e < 7; e++) begin
      string at = $sformatf("%0d", e);
      #1;
      check_val({"b_pass@", at},  32'(bus_b.pass),       32'(pa_t[e]));
      check_val({"b_phase@", at}, 32'(bus_b.phase),      32'(ph_t[e]));
      check_val({"b_step@", at},  32'(bus_b.step),       32'd0);
      check_val({"b_last@", at},  32'(bus_b.phase_last), 32'd1);
      check_val({"b_en@", at},    32'(bus_b.step_en),    32'd1);
      cyc();
    end
    #1;
    check_val("b_end_pass",   32'(bus_b.pass),       32'd3);
    check_val("b_end_busy",   32'(bus_b.busy),       32'd0);
    check_val("b_end_rdone",  32'(bus_b.round_done), 32'd1);
    check_val("b_end_rounds", 32'(bus_b.rounds),     32'd1);
    $display("round on dut_b: 7 busy cycles, rounds now %0d", bus_b.rounds);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mesh_phase_sequencer.md
# mesh_phase_sequencer

Central phase controller for the PE sorting mesh. It replaces per-PE state tracking with one shared sequencer. It steps the array through the three-pass round, PUSH_ADDR, GET_DATA, then COMPUTE. Each sort pass is SORT, then ROW_ALIGN, then COL_ALIGN. It broadcasts the current pass, the current phase and the in-phase step index (the instruction ROM address) to every PE, and it supports start, stall and graceful stop.

## Interface
Parameters:
- SQRT_N, 32: mesh side length; the length in cycles of ROW_ALIGN and of COL_ALIGN.
- SORT_CYCLES, 222: length of the SORT phase in cycles.
- COMPUTE_CYCLES, 3: length of the NOP/compute phase in cycles.
- CNT_WIDTH, 10: step counter width; must hold max(SORT_CYCLES, SQRT_N, COMPUTE_CYCLES)-1.

Ports:
- clk  in  1: single clock; all logic on posedge.
- rst_n  in  1: reset, synchronous, active-low.
- start  in  1: begin rounds; sampled only in IDLE.
- stop  in  1: finish the current round, then go to IDLE.
- stall  in  1: freeze the sequencer for this cycle.
- pass  out  2: 00 PUSH_ADDR, 01 GET_DATA, 10 COMPUTE, 11 IDLE.
- phase  out  3: 000 SORT, 001 ROW_ALIGN, 010 COL_ALIGN, 111 NOP (also in IDLE).
- step  out  CNT_WIDTH: index within the current phase, 0..len-1.
- step_en  out  1: PEs execute `step` this cycle; equals busy & ~stall (combinational).
- phase_last  out  1: step == len-1 of the current phase.
- busy  out  1: pass != IDLE.
- round_done  out  1: one-cycle pulse after a round completes.
- rounds  out  16: count of completed rounds.

## Operation
- Phase lengths: SORT = SORT_CYCLES, ROW_ALIGN = SQRT_N, COL_ALIGN = SQRT_N, NOP = COMPUTE_CYCLES.
- Round order:
  - PUSH_ADDR: SORT → ROW_ALIGN → COL_ALIGN.
  - GET_DATA: SORT → ROW_ALIGN → COL_ALIGN.
  - COMPUTE: NOP.
- Round length is 2·(SORT_CYCLES+2·SQRT_N)+COMPUTE_CYCLES active cycles; 575 with the default parameters.
- States:
  - IDLE (pass=11, phase=111, step=0).
  - Active states are the (pass, phase) pairs listed in the round order above.
- Step counter:
  - Increments on each cycle with step_en=1.
  - On step_en with phase_last=1, step returns to 0 and (pass, phase) advances to the next entry.
- After COMPUTE/NOP completes:
  - If stop_pending is set, go to IDLE and clear stop_pending.
  - Otherwise return to PUSH_ADDR/SORT, step 0.
- stop_pending:
  - Set by stop=1 on any cycle while busy.
  - Set by stop=1 coincident with an accepted start, which gives exactly one round.
  - Cleared only when IDLE is entered or on reset.
- stall=1: pass, phase, step, stop_pending and rounds all hold. stop is still captured while stalled.
- round_done=1 and rounds+1 occur on the cycle after the final NOP step executes. rounds wraps from 0xFFFF to 0.
- Phases of length 1: step stays 0 and phase_last is constantly 1 for that phase.

## Timing
- Reset values: pass=11, phase=111, step=0, busy=0, step_en=0, phase_last=0, round_done=0, rounds=0, stop_pending=0.
- start latency: start=1 in IDLE at edge k gives PUSH_ADDR/SORT, step=0, busy=1 in cycle k+1.
- start while busy is ignored.
- start with stall=1 in IDLE is still accepted: the transition occurs and stall applies only to stepping.
- Phase transition: the cycle after (step_en & phase_last) shows the new phase with step=0. There are no bubble cycles between phases or between rounds.
- Return to IDLE: the cycle after the final NOP step shows pass=11 with busy=0, and round_done=1 in that same cycle.
- Reset mid-operation: reset is synchronous. On the edge with rst_n=0 all state returns to the reset values, regardless of stall, start or stop. The abandoned round does not count.
- All outputs except step_en are registered.

## Test plan
Unless stated otherwise, parameters are SQRT_N=2, SORT_CYCLES=5, COMPUTE_CYCLES=3, so one round is 21 active cycles.
- **Single round:** start and stop pulsed together.
  - PUSH_ADDR/SORT runs steps 0..4, then ROW_ALIGN steps 0..1, then COL_ALIGN steps 0..1.
  - GET_DATA repeats the same sequence, then COMPUTE/NOP runs steps 0..2.
  - Next cycle: IDLE, round_done=1, rounds=1. Total 21 busy cycles.
- **Continuous:** start once, stop asserted during cycle 30.
  - Round 1 ends; PUSH_ADDR/SORT step 0 follows immediately.
  - IDLE is entered after round 2; rounds=2; round_done pulses twice, 21 cycles apart.
- **Stall:** stall held 4 cycles at GET_DATA/ROW_ALIGN step 1.
  - step_en=0 and all outputs frozen for those 4 cycles.
  - Sequencing resumes into COL_ALIGN step 0; the round takes 25 cycles.
- **Reset mid-round:** rst_n=0 for one cycle at PUSH_ADDR/COL_ALIGN step 1.
  - Next cycle: IDLE, step=0, rounds=0.
  - A fresh start then runs a full 21-cycle round.
- **Ignored start and wrap:**
  - start pulses while busy have no effect.
  - With rounds forced to 0xFFFF, one completed round gives rounds=0 and round_done=1.
- **Unit lengths:** SQRT_N=1, SORT_CYCLES=1, COMPUTE_CYCLES=1.
  - The round is 7 cycles.
  - phase_last=1 and step=0 in every active cycle.
